// File: rtl/rcs_seq_nbit_if.sv
// Operand/result handshake bundle for rcs_seq_nbit.
// The ovf signal exists only when RCS_OVF_EN is defined.
interface rcs_seq_nbit_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             mode;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             res_valid;
  logic             res_ready;
`ifdef RCS_OVF_EN
  logic             ovf;

  modport master (
    output start_valid, a, b, borrow_in, mode, res_ready,
    input  start_ready, diff, borrow, res_valid, ovf
  );
  modport slave (
    input  start_valid, a, b, borrow_in, mode, res_ready,
    output start_ready, diff, borrow, res_valid, ovf
  );
`else
  modport master (
    output start_valid, a, b, borrow_in, mode, res_ready,
    input  start_ready, diff, borrow, res_valid
  );
  modport slave (
    input  start_valid, a, b, borrow_in, mode, res_ready,
    output start_ready, diff, borrow, res_valid
  );
`endif
endinterface

// File: rtl/rcs_seq_nbit.sv
// Multi-cycle ripple-carry subtractor/adder: one CHUNK-bit slice per clock.
// Define RCS_OVF_EN to add the registered signed-overflow output ovf.
module rcs_seq_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rcs_seq_nbit_if.slave bus
);
  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_params
      $error("rcs_seq_nbit: WIDTH must be a positive multiple of CHUNK, CHUNK >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
`ifdef RCS_OVF_EN
  logic             ovf_q, ovf_d;
  logic             ovf_slice;
`endif

  logic [CHUNK-1:0] a_sl, b_sl, d_sl;
  logic [CHUNK:0]   sum_sl, a_ext, b_ext, cy_ext;
  logic             cy_out;

  // Single slice datapath; the top bit of the (CHUNK+1)-bit result is the carry or borrow.
  always_comb begin
    a_sl   = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_sl   = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    a_ext  = {1'b0, a_sl};
    b_ext  = {1'b0, b_sl};
    cy_ext = {{CHUNK{1'b0}}, cy_q};
    if (mode_q) begin
      sum_sl = a_ext + b_ext + cy_ext;
    end else begin
      sum_sl = a_ext - b_ext - cy_ext;
    end
    d_sl   = sum_sl[CHUNK-1:0];
    cy_out = sum_sl[CHUNK];
`ifdef RCS_OVF_EN
    // Only meaningful on the last slice, where bit CHUNK-1 is the word's sign bit.
    if (mode_q) begin
      ovf_slice = (a_sl[CHUNK-1] == b_sl[CHUNK-1]) && (d_sl[CHUNK-1] != a_sl[CHUNK-1]);
    end else begin
      ovf_slice = (a_sl[CHUNK-1] != b_sl[CHUNK-1]) && (d_sl[CHUNK-1] != a_sl[CHUNK-1]);
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef RCS_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          cy_d    = bus.borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(cnt_q)*CHUNK +: CHUNK] = d_sl;
        cy_d = cy_out;
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          borrow_d = cy_out;
`ifdef RCS_OVF_EN
          ovf_d    = ovf_slice;
`endif
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef RCS_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef RCS_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.diff        = diff_q;
  assign bus.borrow      = borrow_q;
`ifdef RCS_OVF_EN
  assign bus.ovf         = ovf_q;
`endif
endmodule

// File: tb/tb_rcs_seq_nbit.sv
// Directed and swept checks of rcs_seq_nbit at 16/4, 4/1 and 8/8.
// Define RCS_OVF_EN to also check the ovf output.
module tb_rcs_seq_nbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  rcs_seq_nbit_if #(.WIDTH(16)) m16 ();
  rcs_seq_nbit_if #(.WIDTH(4))  m4 ();
  rcs_seq_nbit_if #(.WIDTH(8))  m8 ();

  rcs_seq_nbit #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16.slave));
  rcs_seq_nbit #(.WIDTH(4),  .CHUNK(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(m4.slave));
  rcs_seq_nbit #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic in wide integers.
  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic bin, input logic md,
                                    output logic [31:0] d, output logic bo, output logic ov);
    longint mask, half, r, sa, sb, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (md) r = longint'(a) + longint'(b) + longint'(bin);
    else    r = longint'(a) - longint'(b) - longint'(bin);
    d  = 32'(r & mask);
    bo = md ? (r > mask) : (r < 0);
    sa = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    if (md) sr = sa + sb + longint'(bin);
    else    sr = sa - sb - longint'(bin);
    ov = (sr < -half) || (sr > half - 1);
  endfunction

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic bin, input logic md,
                      input logic [15:0] exp_d, input logic exp_bo, input logic exp_ov);
    int lat;
    @(negedge clk);
    m16.a = a; m16.b = b; m16.borrow_in = bin; m16.mode = md;
    m16.start_valid = 1'b1;
    @(posedge clk); #1;
    m16.start_valid = 1'b0;
    lat = 0;
    while (!m16.res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op16 %s: a=%h b=%h bin=%0d mode=%0d -> diff=%h borrow=%0d lat=%0d",
             tag, a, b, bin, md, m16.diff, m16.borrow, lat);
    expect_eq({tag, "_lat"}, 32'(lat), 32'd4);
    expect_eq({tag, "_diff"}, 32'(m16.diff), 32'(exp_d));
    expect_eq({tag, "_borrow"}, 32'(m16.borrow), 32'(exp_bo));
`ifdef RCS_OVF_EN
    expect_eq({tag, "_ovf"}, 32'(m16.ovf), 32'(exp_ov));
`else
    if (exp_ov === 1'bx) $display("op16 %s: unknown ovf expectation", tag);
`endif
    m16.res_ready = 1'b1;
    @(posedge clk); #1;
    m16.res_ready = 1'b0;
    expect_eq({tag, "_sready_after"}, 32'(m16.start_ready), 32'd1);
    expect_eq({tag, "_rvalid_after"}, 32'(m16.res_valid), 32'd0);
    expect_eq({tag, "_diff_hold"}, 32'(m16.diff), 32'(exp_d));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin, input logic md);
    int lat;
    logic [31:0] ed;
    logic eb, eo;
    ref_model(4, 32'(a), 32'(b), bin, md, ed, eb, eo);
    @(negedge clk);
    m4.a = a; m4.b = b; m4.borrow_in = bin; m4.mode = md;
    m4.start_valid = 1'b1;
    @(posedge clk); #1;
    m4.start_valid = 1'b0;
    lat = 0;
    while (!m4.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op4 a=%h b=%h bin=%0d mode=%0d -> diff=%h borrow=%0d", a, b, bin, md, m4.diff, m4.borrow);
    expect_eq("w4_lat", 32'(lat), 32'd4);
    expect_eq("w4_diff", 32'(m4.diff), ed);
    expect_eq("w4_borrow", 32'(m4.borrow), 32'(eb));
`ifdef RCS_OVF_EN
    expect_eq("w4_ovf", 32'(m4.ovf), 32'(eo));
`endif
    m4.res_ready = 1'b1;
    @(posedge clk); #1;
    m4.res_ready = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic md);
    int lat;
    logic [31:0] ed;
    logic eb, eo;
    ref_model(8, 32'(a), 32'(b), bin, md, ed, eb, eo);
    @(negedge clk);
    m8.a = a; m8.b = b; m8.borrow_in = bin; m8.mode = md;
    m8.start_valid = 1'b1;
    @(posedge clk); #1;
    m8.start_valid = 1'b0;
    lat = 0;
    while (!m8.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op8 a=%h b=%h bin=%0d mode=%0d -> diff=%h borrow=%0d", a, b, bin, md, m8.diff, m8.borrow);
    expect_eq("w8_lat", 32'(lat), 32'd1);
    expect_eq("w8_diff", 32'(m8.diff), ed);
    expect_eq("w8_borrow", 32'(m8.borrow), 32'(eb));
`ifdef RCS_OVF_EN
    expect_eq("w8_ovf", 32'(m8.ovf), 32'(eo));
`endif
    m8.res_ready = 1'b1;
    @(posedge clk); #1;
    m8.res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    m16.start_valid = 1'b0; m16.res_ready = 1'b0; m16.a = '0; m16.b = '0; m16.borrow_in = 1'b0; m16.mode = 1'b0;
    m4.start_valid  = 1'b0; m4.res_ready  = 1'b0; m4.a  = '0; m4.b  = '0; m4.borrow_in  = 1'b0; m4.mode  = 1'b0;
    m8.start_valid  = 1'b0; m8.res_ready  = 1'b0; m8.a  = '0; m8.b  = '0; m8.borrow_in  = 1'b0; m8.mode  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("reset: start_ready=%0d res_valid=%0d diff=%h borrow=%0d",
             m16.start_ready, m16.res_valid, m16.diff, m16.borrow);
    expect_eq("rst_start_ready", 32'(m16.start_ready), 32'd1);
    expect_eq("rst_res_valid", 32'(m16.res_valid), 32'd0);
    expect_eq("rst_diff", 32'(m16.diff), 32'd0);
    expect_eq("rst_borrow", 32'(m16.borrow), 32'd0);
`ifdef RCS_OVF_EN
    expect_eq("rst_ovf", 32'(m16.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Hand-computed 16-bit vectors: tag, a, b, bin, mode, diff, borrow, ovf
    op16("basic_sub", 16'h1234, 16'h0234, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    op16("wrap_sub",  16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    op16("bin_sub",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    op16("cin_add",   16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    op16("plain_add", 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    op16("carry_add", 16'hA5A5, 16'h5A5B, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    op16("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    op16("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    op16("small_sub", 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Backpressure: 0x4000 - 0x0001 = 0x3FFF, held while other operands are offered.
    @(negedge clk);
    m16.a = 16'h4000; m16.b = 16'h0001; m16.borrow_in = 1'b0; m16.mode = 1'b0;
    m16.start_valid = 1'b1;
    @(posedge clk); #1;
    m16.start_valid = 1'b0;
    lat = 0;
    while (!m16.res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    expect_eq("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      $display("bp cycle %0d: res_valid=%0d diff=%h start_ready=%0d", i, m16.res_valid, m16.diff, m16.start_ready);
      expect_eq("bp_res_valid", 32'(m16.res_valid), 32'd1);
      expect_eq("bp_diff", 32'(m16.diff), 32'h3FFF);
      expect_eq("bp_start_ready", 32'(m16.start_ready), 32'd0);
      m16.a = 16'hFFFF; m16.b = 16'h0000; m16.mode = 1'b1; m16.borrow_in = 1'b1;
      m16.start_valid = 1'b1;
    end
    @(negedge clk);
    expect_eq("bp_diff_last", 32'(m16.diff), 32'h3FFF);
    m16.start_valid = 1'b0;
    m16.res_ready = 1'b1;
    @(posedge clk); #1;
    m16.res_ready = 1'b0;
    $display("bp release: start_ready=%0d res_valid=%0d diff=%h", m16.start_ready, m16.res_valid, m16.diff);
    expect_eq("bp_sready_after", 32'(m16.start_ready), 32'd1);
    expect_eq("bp_rvalid_after", 32'(m16.res_valid), 32'd0);

    // Reset after two slices have been computed.
    @(negedge clk);
    m16.a = 16'hABCD; m16.b = 16'h1111; m16.borrow_in = 1'b0; m16.mode = 1'b0;
    m16.start_valid = 1'b1;
    @(posedge clk); #1;
    m16.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    $display("mid-run reset: start_ready=%0d res_valid=%0d diff=%h borrow=%0d",
             m16.start_ready, m16.res_valid, m16.diff, m16.borrow);
    expect_eq("mrst_start_ready", 32'(m16.start_ready), 32'd1);
    expect_eq("mrst_res_valid", 32'(m16.res_valid), 32'd0);
    expect_eq("mrst_diff", 32'(m16.diff), 32'd0);
    expect_eq("mrst_borrow", 32'(m16.borrow), 32'd0);
    rst_n = 1'b1;
    op16("post_rst", 16'h00FF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0);

    // WIDTH=4/CHUNK=1: every operand combination.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 4; ic++)
          op4(4'(ia), 4'(ib), ic[0], ic[1]);

    // WIDTH=8/CHUNK=8: strided grid including 0x00, 0x88 and 0xFF.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 4; ic++)
          op8(8'(ia * 17), 8'(ib * 17), ic[0], ic[1]);
    op8(8'h80, 8'h01, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
